// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller with per-slot anti-ghosting
// blank and a shadow/display register pair that is committed only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Value,
  input  logic [3:0]  DpIn,
  input  logic [3:0]  BlankIn,
  input  logic        Load,
  output logic        Pending,
  output logic        FrameTick,
  output logic [1:0]  DigitAddr,
  output logic [3:0]  Anode,
  output logic [6:0]  Seg,
  output logic        Dp
);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow_val, disp_val;
  logic [3:0]       shadow_dp, disp_dp;
  logic [3:0]       shadow_blank, disp_blank;
  logic             pending;
  logic             frame_tick;
  logic             slot_end;
  logic             commit;
  logic             in_blank;
  logic             dark;
  logic [3:0]       nibble;

  assign slot_end = (cnt == CNT_W'(DIGIT_TICKS - 1));
  assign commit   = slot_end && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= 2'd0;
      shadow_val   <= 16'h0000;
      shadow_dp    <= 4'b0000;
      shadow_blank <= 4'b1111;
      disp_val     <= 16'h0000;
      disp_dp      <= 4'b0000;
      disp_blank   <= 4'b1111;
      pending      <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Display takes the pre-edge shadow, so a Load on the commit edge waits a frame.
      if (commit && pending) begin
        disp_val   <= shadow_val;
        disp_dp    <= shadow_dp;
        disp_blank <= shadow_blank;
      end
      if (Load) begin
        shadow_val   <= Value;
        shadow_dp    <= DpIn;
        shadow_blank <= BlankIn;
        pending      <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
      // Registered so the frame pulse cannot appear while reset holds idx=0, cnt=0.
      frame_tick <= commit;
    end
  end

  generate
    if (BLANK_TICKS > 0) begin : g_blank
      assign in_blank = (cnt < CNT_W'(BLANK_TICKS));
    end else begin : g_noblank
      assign in_blank = 1'b0;
    end
  endgenerate

  assign dark      = in_blank || disp_blank[idx];
  assign nibble    = disp_val[{idx, 2'b00} +: 4];
  assign Pending   = pending;
  assign FrameTick = frame_tick;
  assign DigitAddr = idx;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    Anode = 4'b1111;
    Seg   = 7'h7F;
    Dp    = 1'b1;
    if (!dark) begin
      Anode = ~(4'b0001 << idx);
      Seg   = hex_seg(nibble);
      Dp    = ~disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed plan steps plus random loads,
// compared each cycle against a cycle-count based reference model.
module tb_seven_seg_scan_ctrl;
  localparam int DT = 8;
  localparam int BT = 2;
  localparam int FRAME = 4 * DT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Value;
  logic [3:0]  DpIn, BlankIn;
  logic        Load;
  logic        Pending, FrameTick, Dp;
  logic [1:0]  DigitAddr;
  logic [3:0]  Anode;
  logic [6:0]  Seg;

  int errors = 0;
  int checks = 0;

  // Reference model: n = clock edges since reset release; slot position follows from n.
  int          n;
  logic [15:0] s_val, m_val;
  logic [3:0]  s_dp, m_dp, s_bl, m_bl;
  logic        m_pend;
  logic [6:0]  seg_tab [16];

  seven_seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Value(Value), .DpIn(DpIn), .BlankIn(BlankIn),
    .Load(Load), .Pending(Pending), .FrameTick(FrameTick), .DigitAddr(DigitAddr),
    .Anode(Anode), .Seg(Seg), .Dp(Dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    s_val = 16'h0; s_dp = 4'h0; s_bl = 4'hF;
    m_val = 16'h0; m_dp = 4'h0; m_bl = 4'hF;
    m_pend = 1'b0;
  endtask

  task automatic check_all();
    int i, c;
    logic dark;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic exp_dp;
    logic [15:0] sh;
    i = (n / DT) % 4;
    c = n % DT;
    dark = (c < BT) || m_bl[i];
    sh = m_val >> (4 * i);
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    if (!dark) begin
      exp_an = 4'hF;
      exp_an[i] = 1'b0;
      exp_seg = seg_tab[sh[3:0]];
      exp_dp = ~m_dp[i];
    end
    chk("anode", {12'h0, Anode}, {12'h0, exp_an});
    chk("seg", {9'h0, Seg}, {9'h0, exp_seg});
    chk("dp", {15'h0, Dp}, {15'h0, exp_dp});
    chk("addr", {14'h0, DigitAddr}, 16'(i));
    chk("frametick", {15'h0, FrameTick}, {15'h0, (n % FRAME == 0) && (n > 0)});
    chk("pending", {15'h0, Pending}, {15'h0, m_pend});
  endtask

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp,
                      input logic [3:0] bl);
    logic commit;
    Load = ld; Value = v; DpIn = dp; BlankIn = bl;
    @(posedge clk);
    commit = (n % FRAME == FRAME - 1);
    if (commit && m_pend) begin
      m_val = s_val; m_dp = s_dp; m_bl = s_bl;
    end
    if (ld) begin
      s_val = v; s_dp = dp; s_bl = bl; m_pend = 1'b1;
    end else if (commit) begin
      m_pend = 1'b0;
    end
    n++;
    #1;
    Load = 1'b0;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic advance_to(input int r);
    for (int j = 0; j < FRAME && (n % FRAME) != r; j++) idle(1);
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n = 1'b0; Load = 1'b0; Value = 16'h0; DpIn = 4'h0; BlankIn = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;

    // 1: idle after reset, display dark
    idle(64);

    // 2: load 1234 at idx 1
    advance_to(9);
    step(1'b1, 16'h1234, 4'h0, 4'h0);
    chk("t2_pend", {15'h0, Pending}, 16'h1);
    advance_to(2);
    chk("t2_seg0", {9'h0, Seg}, 16'h19);
    chk("t2_an0", {12'h0, Anode}, 16'hE);
    idle(64);

    // 3: latest load wins
    advance_to(5);
    step(1'b1, 16'hAAAA, 4'h0, 4'h0);
    idle(4);
    step(1'b1, 16'h0F0F, 4'h0, 4'h0);
    advance_to(3);
    chk("t3_seg0", {9'h0, Seg}, 16'h0E);
    idle(64);

    // 4: load on commit edge with nothing pending
    advance_to(FRAME - 1);
    step(1'b1, 16'h5555, 4'h0, 4'h0);
    chk("t4_pend", {15'h0, Pending}, 16'h1);
    idle(70);

    // 5: per-digit blank and decimal point
    advance_to(7);
    step(1'b1, 16'h9876, 4'b0001, 4'b0100);
    idle(70);

    // random loads
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        idle(1);
    end

    // 6: reset mid-show on digit 2
    advance_to(4);
    step(1'b1, 16'hC3E7, 4'hF, 4'h0);
    idle(64);
    advance_to(2 * DT + 4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_anode", {12'h0, Anode}, 16'hF);
    chk("t6_seg", {9'h0, Seg}, 16'h7F);
    chk("t6_pend", {15'h0, Pending}, 16'h0);
    check_all();
    #4 rst_n = 1'b1;
    idle(64);
    step(1'b1, 16'h4321, 4'h2, 4'h0);
    idle(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It steps a 2-bit digit address (the same Addr1/Addr0 encoding used by our 2-to-4 active-low decoder), drives active-low anodes and hex-encoded active-low segments, and inserts an anti-ghosting blank at the start of each digit slot. New display values arrive through a load/pending handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGIT_TICKS, 50000, clock cycles per digit slot, blank included; legal range 2..2^CNT_W-1.
BLANK_TICKS, 500, cycles at the start of each slot with all anodes off; must be < DIGIT_TICKS; 0 disables blanking.
CNT_W, 16, width of the slot counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
Value  in  16  display value; digit k shows Value[4k+3:4k]; digit 0 is the rightmost digit.
DpIn  in  4  per-digit decimal-point enable, active-high; bit k belongs to digit k.
BlankIn  in  4  per-digit blank, active-high; bit k blanks digit k.
Load  in  1  one-cycle strobe that captures Value/DpIn/BlankIn into the shadow register.
Pending  out  1  high while the shadow register holds data that has not yet been committed.
FrameTick  out  1  one-cycle pulse on the first cycle of each frame (idx=0, cnt=0).
DigitAddr  out  2  current digit index {Addr1,Addr0}.
Anode  out  4  active-low anode enables; Anode[k] belongs to digit k.
Seg  out  7  active-low segments, {g,f,e,d,c,b,a}.
Dp  out  1  active-low decimal point.

Behaviour:
- State: cnt (0..DIGIT_TICKS-1), idx (0..3), shadow {Value, Dp, Blank}, display {Value, Dp, Blank}, Pending.
- Reset (async, rst_n=0): cnt=0, idx=0, Pending=0, shadow and display Value=0, Dp=0, Blank=4'b1111.
- Output values during reset: Anode=4'b1111, Seg=7'h7F, Dp=1, DigitAddr=0, FrameTick=0, Pending=0. Reset asserted mid-slot forces these values immediately.
- Slot counter: cnt increments every cycle. At cnt=DIGIT_TICKS-1, cnt returns to 0 and idx increments (3 wraps to 0). One frame = 4*DIGIT_TICKS cycles.
- Outputs depend only on registered state; there is no combinational path from any input to any output. DigitAddr=idx at all times.
- Blank phase (cnt < BLANK_TICKS), or display Blank[idx]=1: Anode=4'b1111, Seg=7'h7F, Dp=1.
- Show phase (otherwise):
  - Anode: idx0=4'b1110, idx1=4'b1101, idx2=4'b1011, idx3=4'b0111.
  - Seg = hex encoding of display nibble idx. Active-low table, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
  - Dp = ~display Dp[idx].
- Handshake:
  - Load=1 copies the inputs into shadow on that edge and sets Pending=1.
  - Load while Pending=1 overwrites shadow (latest wins); Pending stays 1.
  - Commit edge = the edge where cnt=DIGIT_TICKS-1 and idx=3. If Pending=1 there, display<=shadow and Pending<=0.
  - Load on the commit edge: the new data goes to shadow, display takes the previous shadow contents, and Pending remains 1 for the following frame. If Pending was 0 on that edge, display is unchanged and Pending becomes 1.
- FrameTick=1 exactly when idx=0 and cnt=0, i.e. the cycle after every commit edge, whether or not a commit occurred. FrameTick stays 0 during reset.

Test Plan:
(Bench parameters: DIGIT_TICKS=8, BLANK_TICKS=2.)
1. Reset, then release and run 64 cycles with no Load -> Anode=4'b1111 and Seg=7'h7F throughout; DigitAddr cycles 0,1,2,3 every 8 cycles; FrameTick pulses every 32 cycles.
2. Load Value=16'h1234, DpIn=0, BlankIn=0 at idx=1 -> Pending=1 until the commit edge. In the next frame, slot 0 shows Anode=4'b1111 at cnt 0..1, then Anode=4'b1110 with Seg=7'h19 at cnt 2..7. Slot 3 shows Anode=4'b0111, Seg=7'h79.
3. Load 16'hAAAA, then Load 16'h0F0F before the commit edge -> only 16'h0F0F is displayed: digit0 Seg=7'h0E, digit1 Seg=7'h40; Pending clears after one commit.
4. Load 16'h5555 exactly on the commit edge with Pending=0 -> display unchanged that frame, Pending=1; 16'h5555 (Seg=7'h12) appears one frame later.
5. Commit BlankIn=4'b0100, DpIn=4'b0001 -> during slot 2 Anode stays 4'b1111; Dp=0 only in the show phase of slot 0.
6. Assert rst_n=0 mid-show on digit 2 -> outputs go dark asynchronously and Pending=0. After release, the display stays dark until a new Load is committed.
